// File: rtl/game_pkg.sv
// Shared types for the LED memory game auto player:
// FSM states, LED index type and one-hot helpers.
package game_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_CAPTURE,
      S_QUIET,
      S_PRESS,
      S_GAP
   } state_t;

   typedef logic [1:0] led_idx_t;

   typedef struct packed {
      logic     valid;
      led_idx_t idx;
   } led_dec_t;

   function automatic led_dec_t onehot_dec(input logic [3:0] v);
      led_dec_t d;
      d.valid = 1'b1;
      d.idx   = 2'd0;
      case (v)
         4'b0001: d.idx = 2'd0;
         4'b0010: d.idx = 2'd1;
         4'b0100: d.idx = 2'd2;
         4'b1000: d.idx = 2'd3;
         default: d.valid = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic [3:0] idx_to_sw(input led_idx_t idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/game_pattern_mem.sv
// Recorded LED pattern: one write port, asynchronous read port.
// Out-of-range writes are dropped and out-of-range reads return 0.
module game_pattern_mem
   import game_pkg::*;
#(
   parameter int DEPTH = 6
) (
   input  logic       i_Clk,
   input  logic       i_Wr_En,
   input  logic [7:0] i_Wr_Addr,
   input  led_idx_t   i_Wr_Data,
   input  logic [7:0] i_Rd_Addr,
   output led_idx_t   o_Rd_Data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   led_idx_t mem [DEPTH];

   always_ff @(posedge i_Clk) begin
      if (i_Wr_En && (i_Wr_Addr < 8'(DEPTH)))
         mem[i_Wr_Addr[AW-1:0]] <= i_Wr_Data;
   end

   assign o_Rd_Data = (i_Rd_Addr < 8'(DEPTH)) ?
                      mem[i_Rd_Addr[AW-1:0]] : 2'd0;

endmodule

// File: rtl/game_auto_player.sv
// Autonomous memory-game player: records each round's LED
// sequence and replays it on the switch inputs.
module game_auto_player
   import game_pkg::*;
#(
   parameter int GAME_LIMIT = 6,
   parameter int PRESS_CLKS = 4,
   parameter int GAP_CLKS   = 4
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Start,
   input  logic       i_LED_1,
   input  logic       i_LED_2,
   input  logic       i_LED_3,
   input  logic       i_LED_4,
   input  logic [7:0] i_Score,
   output logic       o_Switch_1,
   output logic       o_Switch_2,
   output logic       o_Switch_3,
   output logic       o_Switch_4,
   output logic       o_Busy,
   output logic       o_Error
);

   localparam int CNT_MAX = (PRESS_CLKS > GAP_CLKS) ?
                            PRESS_CLKS : GAP_CLKS;
   localparam int CW = $clog2(CNT_MAX + 1);

   typedef logic [CW-1:0] cnt_t;

   state_t     state, state_n;
   cnt_t       cnt, cnt_n;
   logic [7:0] wr, wr_n;
   logic [7:0] rd, rd_n;
   logic [7:0] n_len, n_n;
   logic [3:0] sw, sw_n;
   logic       busy, err_n, err;
   logic [3:0] prev_l;

   logic [3:0] leds;
   led_dec_t   dec, prev_dec;
   logic       flash, prev_flash;
   logic       led_evt, abort;
   logic [8:0] score_p1;
   logic [7:0] n_calc;

   logic       we;
   logic [7:0] wa, ra;
   led_idx_t   rd_data;

   assign leds       = {i_LED_4, i_LED_3, i_LED_2, i_LED_1};
   assign dec        = onehot_dec(leds);
   assign prev_dec   = onehot_dec(prev_l);
   assign flash      = (leds != 4'd0) && !dec.valid;
   assign prev_flash = (prev_l != 4'd0) && !prev_dec.valid;
   assign led_evt    = dec.valid && (prev_l == 4'd0);
   assign score_p1   = {1'b0, i_Score} + 9'd1;
   assign n_calc     = (score_p1 > 9'(GAME_LIMIT)) ?
                       8'(GAME_LIMIT) : score_p1[7:0];

   // A flash aborts only on its first cycle so one flash gives one pulse.
   assign abort = (flash && !prev_flash && (state != S_START)) ||
                  (led_evt && ((state == S_PRESS) || (state == S_GAP)));

   game_pattern_mem #(
      .DEPTH(GAME_LIMIT)
   ) u_mem (
      .i_Clk     (i_Clk),
      .i_Wr_En   (we),
      .i_Wr_Addr (wa),
      .i_Wr_Data (dec.idx),
      .i_Rd_Addr (ra),
      .o_Rd_Data (rd_data)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      wr_n    = wr;
      rd_n    = rd;
      n_n     = n_len;
      sw_n    = sw;
      err_n   = 1'b0;
      we      = 1'b0;
      wa      = wr;
      ra      = 8'd0;
      unique case (state)
         S_IDLE: begin
            sw_n = 4'd0;
            if (i_Start) begin
               state_n = S_START;
               sw_n    = 4'b0011;
               cnt_n   = cnt_t'(PRESS_CLKS - 1);
            end else if (led_evt) begin
               we      = 1'b1;
               wa      = 8'd0;
               wr_n    = 8'd1;
               n_n     = n_calc;
               cnt_n   = cnt_t'(GAP_CLKS);
               state_n = (n_calc == 8'd1) ? S_QUIET : S_CAPTURE;
            end
         end
         S_START: begin
            if (cnt == '0) begin
               state_n = S_IDLE;
               sw_n    = 4'd0;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         S_CAPTURE: begin
            if (led_evt) begin
               we   = 1'b1;
               wr_n = wr + 8'd1;
               if (wr + 8'd1 == n_len) begin
                  state_n = S_QUIET;
                  cnt_n   = cnt_t'(GAP_CLKS);
               end
            end
         end
         S_QUIET: begin
            // Quiet window restarts whenever any LED is lit.
            if (leds != 4'd0) begin
               cnt_n = cnt_t'(GAP_CLKS);
            end else if (cnt == '0) begin
               state_n = S_PRESS;
               rd_n    = 8'd0;
               sw_n    = idx_to_sw(rd_data);
               cnt_n   = cnt_t'(PRESS_CLKS - 1);
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         S_PRESS: begin
            if (cnt == '0) begin
               state_n = S_GAP;
               sw_n    = 4'd0;
               cnt_n   = cnt_t'(GAP_CLKS - 1);
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         S_GAP: begin
            ra = rd + 8'd1;
            if (cnt == '0) begin
               rd_n = rd + 8'd1;
               if (rd + 8'd1 == n_len) begin
                  state_n = S_IDLE;
                  wr_n    = 8'd0;
                  rd_n    = 8'd0;
               end else begin
                  state_n = S_PRESS;
                  sw_n    = idx_to_sw(rd_data);
                  cnt_n   = cnt_t'(PRESS_CLKS - 1);
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         default: begin
            state_n = S_IDLE;
            sw_n    = 4'd0;
         end
      endcase
      if (abort) begin
         state_n = S_IDLE;
         sw_n    = 4'd0;
         err_n   = 1'b1;
         wr_n    = 8'd0;
         rd_n    = 8'd0;
         cnt_n   = '0;
         we      = 1'b0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         wr     <= 8'd0;
         rd     <= 8'd0;
         n_len  <= 8'd0;
         sw     <= 4'd0;
         busy   <= 1'b0;
         err    <= 1'b0;
         prev_l <= 4'd0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         wr     <= wr_n;
         rd     <= rd_n;
         n_len  <= n_n;
         sw     <= sw_n;
         busy   <= (state_n != S_IDLE);
         err    <= err_n;
         prev_l <= leds;
      end
   end

   assign {o_Switch_4, o_Switch_3, o_Switch_2, o_Switch_1} = sw;
   assign o_Busy  = busy;
   assign o_Error = err;

endmodule
